// File: rtl/dpe_axis_rr_arbiter.sv
// Packet-granular round-robin merge of N_PORTS AXI-Stream sources onto one stream.
// A grant is held from first beat to tlast; the merged stream leaves through a 2-entry registered buffer.
module dpe_axis_rr_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_PORTS-1:0]                   port_en,
  input  logic [N_PORTS-1:0]                   s_tvalid,
  output logic [N_PORTS-1:0]                   s_tready,
  input  logic [N_PORTS*DATA_WIDTH-1:0]        s_tdata,
  input  logic [N_PORTS*(DATA_WIDTH/8)-1:0]    s_tkeep,
  input  logic [N_PORTS-1:0]                   s_tlast,
  input  logic [N_PORTS*USER_WIDTH-1:0]        s_tuser,
  input  logic [N_PORTS*ID_WIDTH-1:0]          s_tid,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic [DATA_WIDTH-1:0]                m_tdata,
  output logic [DATA_WIDTH/8-1:0]              m_tkeep,
  output logic                                 m_tlast,
  output logic [USER_WIDTH-1:0]                m_tuser,
  output logic [ID_WIDTH-1:0]                  m_tid,
  output logic                                 busy,
  output logic [$clog2(N_PORTS)-1:0]           grant_idx
);

  localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
  localparam int GRANT_WIDTH = $clog2(N_PORTS);
  localparam int BEAT_WIDTH  = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH + ID_WIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e                 state_q;
  logic [GRANT_WIDTH-1:0] grant_q;
  logic [GRANT_WIDTH-1:0] last_q;
  logic                   busy_q;
  logic [1:0]             count_q;
  logic [BEAT_WIDTH-1:0]  head_q;
  logic [BEAT_WIDTH-1:0]  tail_q;

  logic [N_PORTS-1:0]     req;
  logic                   pick_valid;
  logic [GRANT_WIDTH-1:0] pick;
  logic [GRANT_WIDTH:0]   sum;
  logic [BEAT_WIDTH-1:0]  sel_beat;
  logic                   sel_last;
  logic                   ready_lock;
  logic                   push;
  logic                   pop;

  // Search downward in offset so the nearest requester after last_q overrides farther ones.
  always_comb begin
    req        = s_tvalid & port_en;
    pick_valid = 1'b0;
    pick       = '0;
    sum        = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      sum = {1'b0, last_q} + (GRANT_WIDTH+1)'(k);
      if (sum >= (GRANT_WIDTH+1)'(N_PORTS)) begin
        sum = sum - (GRANT_WIDTH+1)'(N_PORTS);
      end
      if (req[sum[GRANT_WIDTH-1:0]]) begin
        pick_valid = 1'b1;
        pick       = sum[GRANT_WIDTH-1:0];
      end
    end
  end

  assign sel_beat = {s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH],
                     s_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH],
                     s_tlast[grant_q],
                     s_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH],
                     s_tid[int'(grant_q)*ID_WIDTH +: ID_WIDTH]};
  assign sel_last = s_tlast[grant_q];

  // A beat moves when valid and ready are both high at a clock edge; ready never depends on
  // valid, and s_tready is decoded from registers only, so m_tready never reaches it.
  assign ready_lock = (state_q == ST_LOCK) && (count_q != 2'd2);
  assign push       = ready_lock && s_tvalid[grant_q];
  assign pop        = m_tvalid && m_tready;

  always_comb begin
    s_tready          = '0;
    s_tready[grant_q] = ready_lock;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GRANT_WIDTH'(N_PORTS - 1);
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick;
            last_q  <= pick;
            busy_q  <= 1'b1;
            state_q <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (push && sel_last) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Head register feeds m_* directly; tail only holds the second beat while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_q  <= sel_beat;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q  <= sel_beat;
          end else if (push) begin
            tail_q  <= sel_beat;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_q  <= tail_q;
            count_q <= 2'd1;
          end
        end
      endcase
    end
  end

  assign m_tvalid = (count_q != 2'd0);
  assign {m_tdata, m_tkeep, m_tlast, m_tuser, m_tid} = head_q;
  assign busy      = busy_q;
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_dpe_axis_rr_arbiter.sv
// Directed bench for dpe_axis_rr_arbiter: per-port packet sources, a beat scoreboard and
// an expected-grant queue, stepped one clock at a time from a single initial block.
module tb_dpe_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int KW = 16;
  localparam int UW = 8;
  localparam int IW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    port_en;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tlast;
  logic [N*UW-1:0] s_tuser;
  logic [N*IW-1:0] s_tid;
  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic [UW-1:0]   m_tuser;
  logic [IW-1:0]   m_tid;
  logic            busy;
  logic [1:0]      grant_idx;

  always #5 clk = ~clk;

  dpe_axis_rr_arbiter #(
    .N_PORTS(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .port_en(port_en),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tid(s_tid),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid),
    .busy(busy), .grant_idx(grant_idx)
  );

  // Source model state, one slot per port.
  int          src_pkts  [N];
  int          src_len   [N];
  int          src_beat  [N];
  int          src_pktno [N];
  bit          src_hold  [N];
  bit          src_fixed [N];
  logic [7:0]  src_user  [N];
  logic [7:0]  src_id    [N];

  logic [191:0] exp_q[$];
  int           exp_grant_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int hs_cnt, first_hs, last_hs, n_pops, busy_cnt;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] m_bundle();
    return 192'({m_tdata, m_tkeep, m_tlast, m_tuser, m_tid});
  endfunction

  function automatic bit src_active();
    bit a = 1'b0;
    for (int p = 0; p < N; p++) if (src_pkts[p] > 0) a = 1'b1;
    return a;
  endfunction

  task automatic present(input int p);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic [IW-1:0] id;
    if (src_fixed[p]) begin
      d  = DW'(src_beat[p] + 1);
      k  = '1;
      u  = src_user[p];
      id = src_id[p];
    end else begin
      d  = {$urandom(), $urandom(), $urandom(), 8'(p), 8'(src_pktno[p]), 16'(src_beat[p])};
      k  = KW'($urandom_range(1, 65535));
      u  = UW'($urandom_range(0, 255));
      id = IW'(p * 16 + src_pktno[p]);
    end
    s_tdata[p*DW +: DW] = d;
    s_tkeep[p*KW +: KW] = k;
    s_tlast[p]          = (src_beat[p] == src_len[p] - 1);
    s_tuser[p*UW +: UW] = u;
    s_tid[p*IW +: IW]   = id;
  endtask

  task automatic load(input int p, input int npkts, input int len);
    src_pkts[p] = npkts;
    src_len[p]  = len;
    src_beat[p] = 0;
    present(p);
    s_tvalid[p] = !src_hold[p];
  endtask

  // Sample the transfers of the current cycle, advance one clock, then update sources.
  task automatic tick();
    bit hs [N];
    if (m_tvalid && m_tready) begin
      n_pops++;
      if (exp_q.size() == 0) chk("sb_unexpected_beat", 192'(exp_q.size()), 192'(1));
      else chk("m_beat", m_bundle(), exp_q.pop_front());
    end
    chk("s_tready_onehot", 192'($countones(s_tready) <= 1), 192'(1));
    for (int p = 0; p < N; p++) begin
      hs[p] = s_tvalid[p] && s_tready[p];
      if (hs[p]) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (src_beat[p] == 0) begin
          if (exp_grant_q.size() == 0) chk("grant_unexpected", 192'(exp_grant_q.size()), 192'(1));
          else chk("grant_order", 192'(p), 192'(exp_grant_q.pop_front()));
        end
        chk("hs_grant_idx", 192'(grant_idx), 192'(p));
        exp_q.push_back(192'({s_tdata[p*DW +: DW], s_tkeep[p*KW +: KW], s_tlast[p],
                              s_tuser[p*UW +: UW], s_tid[p*IW +: IW]}));
      end
    end
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) begin
        src_beat[p]++;
        if (src_beat[p] == src_len[p]) begin
          src_beat[p] = 0;
          src_pkts[p]--;
          src_pktno[p]++;
        end
        if (src_pkts[p] > 0) present(p);
      end
      s_tvalid[p] = (src_pkts[p] > 0) && !src_hold[p];
    end
  endtask

  task automatic drain(input int budget);
    int b = budget;
    while ((src_active() || exp_q.size() != 0) && b > 0) begin
      tick();
      b--;
    end
    chk("drain_done", 192'(src_active() || exp_q.size() != 0), 192'(0));
    chk("grant_queue_empty", 192'(exp_grant_q.size()), 192'(0));
  endtask

  task automatic wait_beat(input int p, input int b);
    int n = 200;
    while (src_beat[p] != b && n > 0) begin
      tick();
      n--;
    end
    chk("wait_beat", 192'(src_beat[p]), 192'(b));
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    for (int p = 0; p < N; p++) begin
      src_pkts[p]  = 0;
      src_beat[p]  = 0;
      src_pktno[p] = 0;
      src_hold[p]  = 1'b0;
      src_fixed[p] = 1'b0;
    end
    s_tvalid = '0;
    m_tready = 1'b1;
    port_en  = '1;
    exp_q.delete();
    exp_grant_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", 192'(m_tvalid), 192'(0));
    chk("rst_s_tready", 192'(s_tready), 192'(0));
    chk("rst_busy", 192'(busy), 192'(0));
    chk("rst_grant_idx", 192'(grant_idx), 192'(0));
    chk("rst_m_payload", m_bundle(), 192'(0));
    rst      = 1'b1;
    hs_cnt   = 0;
    first_hs = -1;
    last_hs  = -1;
    n_pops   = 0;
    busy_cnt = 0;
  endtask

  initial begin
    logic [191:0] snap;
    int c0, hs0, n;
    rst      = 1'b0;
    port_en  = '1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    s_tid    = '0;
    m_tready = 1'b1;

    // Single 4-beat packet on port 2 with fixed payload.
    reset_dut();
    src_fixed[2] = 1'b1;
    src_user[2]  = 8'hA5;
    src_id[2]    = 8'h07;
    exp_grant_q.push_back(2);
    load(2, 1, 4);
    tick();
    chk("t1_m_tvalid_c1", 192'(m_tvalid), 192'(0));
    chk("t1_grant_idx", 192'(grant_idx), 192'(2));
    chk("t1_busy", 192'(busy), 192'(1));
    chk("t1_s_tready", 192'(s_tready), 192'(4'b0100));
    tick();
    chk("t1_m_tvalid_c2", 192'(m_tvalid), 192'(1));
    chk("t1_first_tdata", 192'(m_tdata), 192'(1));
    chk("t1_tuser", 192'(m_tuser), 192'(8'hA5));
    chk("t1_tid", 192'(m_tid), 192'(8'h07));
    drain(100);
    chk("t1_busy_cycles", 192'(busy_cnt), 192'(4));
    chk("t1_beats", 192'(n_pops), 192'(4));
    chk("t1_grant_after", 192'(grant_idx), 192'(2));

    // All four ports stream 2-beat packets back to back.
    reset_dut();
    c0 = cyc;
    for (int p = 0; p < N; p++) load(p, 3, 2);
    for (int r = 0; r < 3; r++) for (int p = 0; p < N; p++) exp_grant_q.push_back(p);
    drain(200);
    chk("t2_beats_in", 192'(hs_cnt), 192'(24));
    chk("t2_beats_out", 192'(n_pops), 192'(24));
    chk("t2_first_accept", 192'(first_hs - c0), 192'(1));
    chk("t2_span", 192'(last_hs - first_hs), 192'(34));

    // Port 1 disabled until port 3 has started its third packet.
    reset_dut();
    port_en = 4'b1101;
    load(1, 1, 3);
    load(3, 4, 2);
    exp_grant_q.push_back(3);
    exp_grant_q.push_back(3);
    exp_grant_q.push_back(3);
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(3);
    n = 200;
    while (src_pkts[3] != 2 && n > 0) begin
      tick();
      n--;
    end
    chk("t3_two_done", 192'(src_pkts[3]), 192'(2));
    chk("t3_port1_waiting", 192'(src_pkts[1]), 192'(1));
    tick();
    port_en = 4'b1111;
    drain(200);

    // Backpressure for cycles 3..7 of an 8-beat packet.
    reset_dut();
    exp_grant_q.push_back(0);
    load(0, 1, 8);
    repeat (3) tick();
    m_tready = 1'b0;
    snap = m_bundle();
    hs0  = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_m_stable", m_bundle(), snap);
      chk("t4_m_tvalid", 192'(m_tvalid), 192'(1));
      chk("t4_s_tready_low", 192'(s_tready), 192'(0));
    end
    chk("t4_accepted_in_stall", 192'(hs_cnt - hs0), 192'(1));
    m_tready = 1'b1;
    drain(100);
    chk("t4_beats_in", 192'(hs_cnt), 192'(8));
    chk("t4_beats_out", 192'(n_pops), 192'(8));

    // Source bubble and port_en cleared on the granted port mid-packet.
    reset_dut();
    exp_grant_q.push_back(2);
    exp_grant_q.push_back(3);
    load(2, 1, 6);
    load(3, 1, 2);
    wait_beat(2, 2);
    src_hold[2] = 1'b1;
    s_tvalid[2] = 1'b0;
    port_en[2]  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_busy_held", 192'(busy), 192'(1));
      chk("t5_grant_held", 192'(grant_idx), 192'(2));
      chk("t5_port3_blocked", 192'(s_tready[3]), 192'(0));
      if (i == 2) src_hold[2] = 1'b0;
      tick();
    end
    drain(100);
    chk("t5_grant_final", 192'(grant_idx), 192'(3));

    // Reset in the middle of a 5-beat packet on port 1.
    reset_dut();
    exp_grant_q.push_back(1);
    load(1, 1, 5);
    wait_beat(1, 2);
    rst = 1'b0;
    #1;
    chk("t6_m_tvalid", 192'(m_tvalid), 192'(0));
    chk("t6_s_tready", 192'(s_tready), 192'(0));
    chk("t6_busy", 192'(busy), 192'(0));
    reset_dut();
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    load(0, 1, 2);
    load(1, 1, 2);
    drain(100);
    chk("t6_beats_out", 192'(n_pops), 192'(4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
